// File: rtl/mips_pkg.sv
// Shared MIPS definitions: default widths, instruction word type,
// opcode/funct encodings and the built-in program image.
package mips_pkg;

   localparam int DEFAULT_ADDR_W = 8;
   localparam int DEFAULT_DATA_W = 32;
   localparam int IMAGE_WORDS    = 64;

   typedef logic [31:0] instr_t;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   // R-type funct codes
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;

   // Register numbers used by the program
   localparam logic [4:0] R_ZERO = 5'd0;
   localparam logic [4:0] R_T0   = 5'd8;
   localparam logic [4:0] R_T1   = 5'd9;
   localparam logic [4:0] R_T2   = 5'd10;
   localparam logic [4:0] R_T3   = 5'd11;
   localparam logic [4:0] R_T4   = 5'd12;

   function automatic instr_t enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                    input logic [4:0] rd, input logic [5:0] funct);
      return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
   endfunction

   function automatic instr_t enc_i(input logic [5:0] op, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic instr_t enc_j(input logic [25:0] target);
      return {OP_J, target};
   endfunction

   // Program image, one word per entry; everything past the jump is nop.
   localparam instr_t PROG_IMAGE [IMAGE_WORDS] = '{
      0:       enc_i(OP_ADDI, R_ZERO, R_T0, 16'd5),    // addi $t0,$zero,5
      1:       enc_i(OP_ADDI, R_ZERO, R_T1, 16'd10),   // addi $t1,$zero,10
      2:       enc_r(R_T0, R_T1, R_T2, FN_ADD),        // add  $t2,$t0,$t1
      3:       enc_r(R_T1, R_T0, R_T3, FN_SUB),        // sub  $t3,$t1,$t0
      4:       enc_i(OP_SW, R_ZERO, R_T2, 16'd0),      // sw   $t2,0($zero)
      5:       enc_i(OP_LW, R_ZERO, R_T4, 16'd0),      // lw   $t4,0($zero)
      6:       enc_i(OP_BEQ, R_T2, R_T4, 16'd1),       // beq  $t2,$t4,+1
      7:       32'h0000_0000,                          // nop
      8:       enc_j(26'd0),                           // j    0
      default: 32'h0000_0000
   };

endpackage

// File: rtl/instruction_memory.sv
// Read-only, big-endian byte-array instruction ROM. The fetch path is purely
// combinational from pc; clk and rst exist only for interface uniformity.
module instruction_memory
   import mips_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] instruct
);

   localparam int NUM_BYTES = 2 ** ADDR_W;
   localparam int NUM_WORDS = NUM_BYTES / 4;

   // Byte-addressed storage, filled from the word image (MSB byte at lowest address).
   logic [7:0] rom_bytes [NUM_BYTES];

   for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      instr_t word_init;
      if (gi < IMAGE_WORDS) begin : g_img
         assign word_init = PROG_IMAGE[gi];
      end else begin : g_pad
         assign word_init = '0;
      end
      assign rom_bytes[4*gi + 0] = word_init[31:24];
      assign rom_bytes[4*gi + 1] = word_init[23:16];
      assign rom_bytes[4*gi + 2] = word_init[15:8];
      assign rom_bytes[4*gi + 3] = word_init[7:0];
   end

   // Aligned word base: the two low pc bits are dropped, so misaligned
   // fetches return the enclosing word instead of trapping.
   logic [ADDR_W-1:0] base_addr;
   assign base_addr = {pc[ADDR_W-1:2], 2'b00};

   // Combinational big-endian fetch of the four bytes of the word.
   always_comb begin
      instruct = DATA_W'({rom_bytes[base_addr],
                          rom_bytes[base_addr + ADDR_W'(1)],
                          rom_bytes[base_addr + ADDR_W'(2)],
                          rom_bytes[base_addr + ADDR_W'(3)]});
   end

   // clk, rst and the byte-offset bits intentionally have no effect on the output.
   logic unused_ok;
   assign unused_ok = &{1'b0, clk, rst, pc[1:0]};

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: directed boundary cases plus
// randomized fetches checked against a word-table reference model.
module tb_instruction_memory;

   logic        clk;
   logic        rst;
   logic [7:0]  pc;
   logic [31:0] instruct;
   logic        clk_run;

   int n_cmp;
   int n_bad;

   // Reference: the program listing as plain words, indexed by byte address / 4.
   logic [31:0] ref_words [64];

   instruction_memory #(.ADDR_W(8), .DATA_W(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .pc       (pc),
      .instruct (instruct)
   );

   // Clock only toggles once enabled, so the first check sees no edges at all.
   initial begin
      clk = 1'b0;
      wait (clk_run);
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s pc=%02h got=%08h exp=%08h", tag, pc, got, exp);
      end else begin
         $display("ok   %s pc=%02h got=%08h", tag, pc, got);
      end
   endtask

   function automatic logic [31:0] model(input logic [7:0] addr);
      return ref_words[addr / 4];
   endfunction

   initial begin
      logic [31:0] listing [9];
      n_cmp   = 0;
      n_bad   = 0;
      clk_run = 1'b0;
      rst     = 1'b0;
      pc      = 8'h00;

      listing = '{32'h20080005, 32'h2009000A, 32'h01095020, 32'h01285822,
                  32'hAC0A0000, 32'h8C0C0000, 32'h114C0001, 32'h00000000,
                  32'h08000000};
      for (int i = 0; i < 64; i++) ref_words[i] = (i < 9) ? listing[i] : 32'h0;

      // Valid from time zero with no clock.
      #5;
      check("t0_noclk", instruct, 32'd537395205);

      // Sweep of the programmed words.
      for (int i = 0; i <= 8; i++) begin
         pc = 8'(i * 4);
         #1;
         check("sweep", instruct, listing[i]);
      end

      // Low address bits ignored.
      for (int i = 9; i <= 11; i++) begin
         pc = 8'(i);
         #1;
         check("misalign", instruct, 32'h01095020);
      end

      // Tail of the image and wrap-around.
      pc = 8'h24; #1; check("nop_24", instruct, 32'h0);
      pc = 8'hFC; #1; check("last_fc", instruct, 32'h0);
      pc = 8'h00; #1; check("wrap_00", instruct, 32'h20080005);

      // Reset with pc held: output unaffected across clock edges.
      clk_run = 1'b1;
      pc  = 8'h10;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("rst_hold", instruct, 32'hAC0A0000);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_release", instruct, 32'hAC0A0000);

      // Mid-cycle pc change updates without an edge.
      @(posedge clk);
      #2 pc = 8'h14;
      #1 check("mid_14", instruct, 32'h8C0C0000);
      pc = 8'h18;
      #1 check("mid_18", instruct, 32'h114C0001);

      // Randomized fetches with random reset level, sampled away from edges.
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         pc  = 8'($urandom_range(0, 255));
         rst = 1'($urandom_range(0, 1));
         #1;
         check("rand", instruct, model(pc));
         @(posedge clk); #1;
         check("rand_edge", instruct, model(pc));
      end

      rst = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
